// File: rtl/mem_stage.sv
// mem_stage: data-memory stage behind the ALU. Word loads/stores to an
// internal synchronous RAM, write-back mux, one-cycle load stall.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mem_read     load request
//   mem_write    store request (wins over mem_read when both are set)
//   mem_to_reg   select load data for write-back
//   alu_res      byte address / pass-through value
//   wr_data      store data
//   wb_data      register-file write data
//   stall        holds PC/instruction during the issuing cycle of a load
//   addr_err     sticky misalignment / read+write conflict flag
//   ld_count     saturating count of completed aligned loads
//   st_count     saturating count of performed stores
module mem_stage #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          mem_to_reg,
  input  logic [31:0]   alu_res,
  input  logic [31:0]   wr_data,
  output logic [31:0]   wb_data,
  output logic          stall,
  output logic          addr_err,
  output logic [15:0]   ld_count,
  output logic [15:0]   st_count
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_data_q;
  logic          mis_q;

  logic [AW-1:0] idx;
  logic          aligned;
  logic          do_store;
  logic          do_load;

  // Upper address bits are dropped so addresses wrap modulo 4*DEPTH bytes.
  assign idx      = alu_res[AW+1:2];
  assign aligned  = (alu_res[1:0] == 2'b00);
  assign do_store = (state == IDLE) && mem_write && aligned;
  assign do_load  = (state == IDLE) && mem_read && !mem_write;

  // Stall must rise in the issuing cycle and drop at once under reset.
  assign stall = rst_n && do_load;

  // In LOAD the registered read data is returned; mem_to_reg=1 outside a
  // load is never issued by the control unit, so it also passes alu_res.
  always_comb begin
    wb_data = alu_res;
    if (state == LOAD) begin
      wb_data = mis_q ? 32'h0 : rd_data_q;
    end
  end

  // RAM array: no reset, contents persist across rst_n.
  always_ff @(posedge clk) begin
    if (do_store) begin
      mem[idx] <= wr_data;
    end
  end

  // State machine, read register, sticky error and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_data_q <= 32'h0;
      mis_q     <= 1'b0;
      addr_err  <= 1'b0;
      ld_count  <= '0;
      st_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write) begin
            if (!aligned || mem_read) begin
              addr_err <= 1'b1;
            end
            if (aligned && (st_count != CNT_MAX)) begin
              st_count <= st_count + CW'(1);
            end
          end else if (mem_read) begin
            rd_data_q <= mem[idx];
            mis_q     <= !aligned;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (mis_q) begin
            addr_err <= 1'b1;
          end else if (ld_count != CNT_MAX) begin
            ld_count <= ld_count + CW'(1);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // mem_to_reg only matters for the external write-back convention.
  logic unused_mem_to_reg;
  assign unused_mem_to_reg = mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: stores, loads, wrap-around,
// misalignment, read+write conflict, back-to-back loads, reset abort.
module tb_mem_stage;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic [31:0] alu_res;
  logic [31:0] wr_data;
  logic [31:0] wb_data;
  logic        stall;
  logic        addr_err;
  logic [15:0] ld_count;
  logic [15:0] st_count;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .alu_res    (alu_res),
    .wr_data    (wr_data),
    .wb_data    (wb_data),
    .stall      (stall),
    .addr_err   (addr_err),
    .ld_count   (ld_count),
    .st_count   (st_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic m2r,
                       input logic [31:0] a, input logic [31:0] d);
    mem_read   = rd;
    mem_write  = wr;
    mem_to_reg = m2r;
    alu_res    = a;
    wr_data    = d;
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h55, 32'h0);
    // Reset state (load request held high to show stall is forced low).
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb", wb_data, 32'h55);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_ld", 32'(ld_count), 32'd0);
    check("rst_st", 32'(st_count), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst_n = 1'b1;

    // Store DEADBEEF at 0x10, then load it back.
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    check("st1_stall", 32'(stall), 32'd0);
    step();
    check("st1_cnt", 32'(st_count), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    check("ld1_stall_n", 32'(stall), 32'd1);
    step();
    check("ld1_stall_n1", 32'(stall), 32'd0);
    check("ld1_data", wb_data, 32'hDEADBEEF);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("ld1_cnt", 32'(ld_count), 32'd1);
    check("ld1_stcnt", 32'(st_count), 32'd1);
    check("ld1_err", 32'(addr_err), 32'd0);

    // Store at 0x04, load through the wrapped alias 0x04 + 4*DEPTH.
    drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h12345678);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h4 + 32'(4 * DEPTH), 32'h0);
    step();
    check("wrap_data", wb_data, 32'h12345678);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_ldcnt", 32'(ld_count), 32'd2);
    check("wrap_stcnt", 32'(st_count), 32'd2);

    // Read and write together at 0x08: store only, no stall, error set.
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'hA5A5A5A5);
    check("rw_stall", 32'(stall), 32'd0);
    check("rw_err_pre", 32'(addr_err), 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rw_err", 32'(addr_err), 32'd1);
    check("rw_stcnt", 32'(st_count), 32'd3);
    check("rw_ldcnt", 32'(ld_count), 32'd2);
    drive(1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
    step();
    check("rw_data", wb_data, 32'hA5A5A5A5);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset clears the sticky error and counters but keeps RAM.
    pulse_reset();
    check("rst2_err", 32'(addr_err), 32'd0);
    check("rst2_st", 32'(st_count), 32'd0);

    // Misaligned store at 0x06 is suppressed.
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h6, 32'hFFFFFFFF);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("mis_st_err", 32'(addr_err), 32'd1);
    check("mis_st_cnt", 32'(st_count), 32'd0);
    // Misaligned load at 0x06 returns zero and is not counted.
    drive(1'b1, 1'b0, 1'b1, 32'h6, 32'h0);
    check("mis_ld_stall", 32'(stall), 32'd1);
    step();
    check("mis_ld_data", wb_data, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("mis_ld_cnt", 32'(ld_count), 32'd0);
    // RAM[1] still holds the earlier aligned store.
    drive(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    step();
    check("ram1_keep", wb_data, 32'h12345678);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("ram1_ldcnt", 32'(ld_count), 32'd1);

    // A misaligned load alone sets the sticky error.
    pulse_reset();
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h2, 32'h0);
    step();
    check("misld_err_pre", 32'(addr_err), 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("misld_err", 32'(addr_err), 32'd1);

    // Back-to-back loads of 0x0 and 0x4, reset during the second LOAD.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h11111111);
    step();
    pulse_reset();
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    check("b2b_stall0", 32'(stall), 32'd1);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    check("b2b_stall1", 32'(stall), 32'd0);
    check("b2b_data0", wb_data, 32'h11111111);
    step();
    check("b2b_stall2", 32'(stall), 32'd1);
    check("b2b_cnt1", 32'(ld_count), 32'd1);
    step();
    check("b2b_stall3", 32'(stall), 32'd0);
    check("b2b_data1", wb_data, 32'h12345678);
    #2 rst_n = 1'b0;
    #1;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_wb", wb_data, 32'h4);
    check("abort_cnt", 32'(ld_count), 32'd0);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("abort_cnt2", 32'(ld_count), 32'd0);
    check("abort_idle", 32'(stall), 32'd0);

    // Plain ALU pass-through.
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0042, 32'h0);
    check("pass_wb", wb_data, 32'h42);
    check("pass_stall", 32'(stall), 32'd0);
    step();
    check("pass_wb2", wb_data, 32'h42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
